demux_stream_router: RTL and testbench
======================================

// Module: demux_stream_router
// PURPOSE
// - Registered 1:2 stream router for the 1-bit demux path, generalised to a DATA_W-bit word.
// - Accepts a valid/ready input stream and steers each word to one of two output channels.
//   The channel is chosen by an internal round-robin pointer or by an explicit per-word select.
// - Exports the active select `sel`, so the router also sources the select of any downstream demux.
// - Holds each word in a one-entry output register per channel until the consumer takes it.
// PARAMETERS
// - DATA_W  8   width of in_data, out0_data and out1_data.
// - CNT_W   16  width of the per-channel word counters (only with DEMUX_CNT_EN).
// PORTS
// - clk        in   1       clock; all state updates on the rising edge.
// - rst        in   1       synchronous reset, active-high.
// - in_valid   in   1       input word present.
// - in_ready   out  1       router can take the word this cycle.
// - in_data    in   DATA_W  input word.
// - in_sel     in   1       target channel when rr_en=0 (0 -> ch0, 1 -> ch1).
// - rr_en      in   1       1 = round-robin routing; 0 = route by in_sel.
// - sel        out  1       current target channel (combinational).
// - out0_valid out  1       ch0 holds a word.
// - out0_ready in   1       ch0 consumer takes the word.
// - out0_data  out  DATA_W  ch0 word.
// - out1_valid out  1       ch1 holds a word.
// - out1_ready in   1       ch1 consumer takes the word.
// - out1_data  out  DATA_W  ch1 word.
// - cnt0, cnt1 out  CNT_W   words accepted per channel (only with DEMUX_CNT_EN).
// BEHAVIOUR
// - Single clock; synchronous active-high reset on clk, named clk/rst.
// - Reset state: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, ptr=0, cnt0=0, cnt1=0.
//   - rst wins over every other event in the same cycle.
//   - Reset mid-operation discards any held words.
// - Routing state (one flop):
//   - ptr: 0 = ch0 next, 1 = ch1 next; its value is the current state.
//   - Transition: ptr toggles on an accepted word while rr_en=1; it holds otherwise.
// - Channel selection:
//   - sel = rr_en ? ptr : in_sel.
//   - T denotes the channel selected by sel.
// - Handshake:
//   - in_ready = ~outT_valid | outT_ready. This is combinational from outT_ready.
//   - A word is accepted when in_valid & in_ready.
//   - Head-of-line: if T is full and not draining, in_ready=0 even when the other channel is empty.
//   - No skipping in round-robin mode.
// - Accept:
//   - outT_data <= in_data and outT_valid <= 1 at the next edge.
//   - Latency: 1 cycle from acceptance to outT_valid=1.
// - Drain: a channel's valid clears when outX_valid & outX_ready and no new word loads it that cycle.
// - Simultaneous drain and load on the same channel: valid stays 1 and data takes the new word.
//   - Full throughput is 1 word/cycle.
// - Ordering: words leave each channel in acceptance order, with no duplication or loss.
// - Output data holds its value while valid=1 and ready=0.
// - rr_en changes: ptr keeps its value; routing on the change cycle uses the new rr_en.
// - Inputs are ignored when in_valid=0: no state change and the counters do not advance.
// CONFIGURATION
// - Macro DEMUX_CNT_EN defined:
//   - Adds ports cnt0/cnt1.
//   - cntT increments by 1 at every accept and wraps modulo 2^CNT_W.
//   - Counters reset to 0.
// - Macro DEMUX_CNT_EN undefined: the cnt0/cnt1 ports and counter logic are absent.
//   - All other behaviour is identical.
// TESTING
// - Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=0xFF.
//   -> out0_valid=out1_valid=0, both data=0x00, sel=0.
// - Round-robin: rr_en=1, both ready=1, stream 0xA1,0xB2,0xC3,0xD4 back-to-back.
//   -> ch0 gets 0xA1,0xC3 and ch1 gets 0xB2,0xD4, each valid 1 cycle after accept, in_ready stays 1.
// - Backpressure: rr_en=0, in_sel=0, out0_ready=0, send 0x11 then 0x22.
//   -> 0x11 held and in_ready=0 for 0x22.
//   -> raise out0_ready: 0x22 loads on the drain cycle and out0_valid stays 1.
// - Head-of-line: rr_en=1, ptr=1, out1_valid=1, out1_ready=0, out0 empty.
//   -> in_ready=0 and sel=1 until out1_ready=1.
// - Reset mid-operation: both channels full (0x5A, 0xA5), assert rst for 1 cycle.
//   -> both valids 0 and ptr=0 next cycle; the next word goes to ch0.
// - DEMUX_CNT_EN with CNT_W=2: rr_en=0, in_sel=0, send 5 words.
//   -> cnt0=1 (wrapped), cnt1=0.

Source files
------------

// File: rtl/demux_stream_router.sv
// Registered 1:2 stream router: steers each accepted word into a one-entry register per channel,
// by round-robin pointer or explicit select. Optional macro DEMUX_CNT_EN adds per-channel word counters.
module demux_stream_router #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              rr_en,
   output logic              sel,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   typedef enum logic {
      PTR_CH0 = 1'b0,
      PTR_CH1 = 1'b1
   } ptr_t;

   ptr_t              ptr_reg, ptr_next;
   logic [1:0]        valid_reg;
   logic [DATA_W-1:0] data_reg [2];
   logic [1:0]        ch_ready;
   logic [1:0]        load;
   logic              accept;

   assign ch_ready = {out1_ready, out0_ready};

   // Head-of-line: only the selected channel's state gates the input.
   assign sel      = rr_en ? (ptr_reg == PTR_CH1) : in_sel;
   assign in_ready = ~valid_reg[sel] | ch_ready[sel];
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= PTR_CH0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (accept && rr_en) begin
         ptr_next = (ptr_reg == PTR_CH0) ? PTR_CH1 : PTR_CH0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         assign load[gi] = accept & (sel == gi[0]);

         // A load on the drain cycle keeps valid high and replaces the word.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
               data_reg[gi]  <= '0;
            end else if (load[gi]) begin
               valid_reg[gi] <= 1'b1;
               data_reg[gi]  <= in_data;
            end else if (ch_ready[gi]) begin
               valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   assign out0_valid = valid_reg[0];
   assign out1_valid = valid_reg[1];
   assign out0_data  = data_reg[0];
   assign out1_data  = data_reg[1];

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_reg [2];

   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg[gi] <= '0;
            end else if (load[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign cnt0 = cnt_reg[0];
   assign cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router: per-channel expected-word queues fed on accept,
// checked against the outputs every cycle; directed scenarios followed by a random phase.
module tb_demux_stream_router;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_sel;
   logic              rr_en;
   logic              sel;
   logic              out0_valid, out1_valid;
   logic              out0_ready, out1_ready;
   logic [DATA_W-1:0] out0_data, out1_data;
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0]  cnt0, cnt1;
   logic [CNT_W-1:0]  m_cnt0, m_cnt1;
`endif

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] q0[$], q1[$];
   logic [DATA_W-1:0] got0[$], got1[$];
   logic              m_ptr;

   always #5 clk = ~clk;

   demux_stream_router #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .rr_en(rr_en), .sel(sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef DEMUX_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: check combinational/registered outputs against the model, then advance the model.
   task automatic step();
      logic exp_sel, exp_rdy, acc, pop0, pop1;
      exp_sel = 1'b0;
      acc     = 1'b0;
      pop0    = 1'b0;
      pop1    = 1'b0;
      #1;
      if (!rst) begin
         exp_sel = rr_en ? m_ptr : in_sel;
         exp_rdy = exp_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
         acc     = in_valid && exp_rdy;
         pop0    = (q0.size() != 0) && out0_ready;
         pop1    = (q1.size() != 0) && out1_ready;
         check_val("sel", sel, exp_sel);
         check_val("in_ready", in_ready, exp_rdy);
         check_val("out0_valid", out0_valid, q0.size() != 0);
         check_val("out1_valid", out1_valid, q1.size() != 0);
         if (q0.size() != 0) check_val("out0_data", out0_data, q0[0]);
         if (q1.size() != 0) check_val("out1_data", out1_data, q1[0]);
`ifdef DEMUX_CNT_EN
         check_val("cnt0", cnt0, m_cnt0);
         check_val("cnt1", cnt1, m_cnt1);
`endif
         $display("cyc t=%0t v=%0b d=%02h sel=%0b rdy=%0b acc=%0b o0=%0b:%02h o1=%0b:%02h",
                  $time, in_valid, in_data, sel, in_ready, acc,
                  out0_valid, out0_data, out1_valid, out1_data);
      end
      @(posedge clk);
      if (rst) begin
         q0.delete();
         q1.delete();
         m_ptr = 1'b0;
`ifdef DEMUX_CNT_EN
         m_cnt0 = '0;
         m_cnt1 = '0;
`endif
      end else begin
         if (pop0) got0.push_back(q0.pop_front());
         if (pop1) got1.push_back(q1.pop_front());
         if (acc) begin
            if (exp_sel) q1.push_back(in_data);
            else         q0.push_back(in_data);
`ifdef DEMUX_CNT_EN
            if (exp_sel) m_cnt1 = m_cnt1 + 1'b1;
            else         m_cnt0 = m_cnt0 + 1'b1;
`endif
            if (rr_en) m_ptr = ~m_ptr;
         end
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 1'b0; rr_en = 1'b1;
      out0_ready = 1'b0; out1_ready = 1'b0;
      m_ptr = 1'b0;
`ifdef DEMUX_CNT_EN
      m_cnt0 = '0; m_cnt1 = '0;
`endif
      @(negedge clk);
      // Reset held 2 cycles with a word presented.
      do_reset(2);
      in_valid = 1'b0;
      #1;
      check_val("rst_out0_valid", out0_valid, 1'b0);
      check_val("rst_out1_valid", out1_valid, 1'b0);
      check_val("rst_out0_data", out0_data, 8'h00);
      check_val("rst_out1_data", out1_data, 8'h00);
      check_val("rst_sel", sel, 1'b0);
      step();

      // Round-robin, full throughput.
      out0_ready = 1'b1; out1_ready = 1'b1;
      got0.delete(); got1.delete();
      send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      repeat (2) step();
      check_val("rr_ch0_count", got0.size(), 2);
      check_val("rr_ch1_count", got1.size(), 2);
      if (got0.size() == 2) begin
         check_val("rr_ch0_w0", got0[0], 8'hA1);
         check_val("rr_ch0_w1", got0[1], 8'hC3);
      end
      if (got1.size() == 2) begin
         check_val("rr_ch1_w0", got1[0], 8'hB2);
         check_val("rr_ch1_w1", got1[1], 8'hD4);
      end

      // Backpressure on ch0, then drain-and-load on the same cycle.
      rr_en = 1'b0; in_sel = 1'b0; out0_ready = 1'b0;
      send(8'h11);
      in_valid = 1'b1; in_data = 8'h22;
      #1;
      check_val("bp_in_ready", in_ready, 1'b0);
      step(); step();
      out0_ready = 1'b1;
      step();
      in_valid = 1'b0; out0_ready = 1'b0;
      #1;
      check_val("bp_reload_valid", out0_valid, 1'b1);
      check_val("bp_reload_data", out0_data, 8'h22);
      out0_ready = 1'b1;
      repeat (2) step();

      // Head-of-line: ptr=1, ch1 full and stalled, ch0 empty.
      do_reset(1);
      rr_en = 1'b1; out0_ready = 1'b1; out1_ready = 1'b0;
      send(8'h31); send(8'h32); send(8'h33);
      step();
      in_valid = 1'b1; in_data = 8'h34;
      repeat (3) begin
         #1;
         check_val("hol_in_ready", in_ready, 1'b0);
         check_val("hol_sel", sel, 1'b1);
         step();
      end
      out1_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();

      // Reset mid-operation with both channels full.
      rr_en = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
      in_sel = 1'b0; send(8'h5A);
      in_sel = 1'b1; send(8'hA5);
      step();
      do_reset(1);
      rr_en = 1'b1;
      #1;
      check_val("mid_rst_v0", out0_valid, 1'b0);
      check_val("mid_rst_v1", out1_valid, 1'b0);
      check_val("mid_rst_sel", sel, 1'b0);
      send(8'h77);
      #1;
      check_val("mid_rst_next_ch0", out0_valid, 1'b1);
      check_val("mid_rst_next_data", out0_data, 8'h77);
      out0_ready = 1'b1;
      step();

`ifdef DEMUX_CNT_EN
      // Counter wrap at CNT_W=2.
      do_reset(1);
      rr_en = 1'b0; in_sel = 1'b0; out0_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(8'h40 + i[7:0]);
      #1;
      check_val("cnt0_wrap", cnt0, 2'd1);
      check_val("cnt1_zero", cnt1, 2'd0);
      step();
`endif

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         in_valid   = $urandom_range(0, 1);
         in_data    = 8'($urandom);
         in_sel     = $urandom_range(0, 1);
         rr_en      = ($urandom_range(0, 3) != 0);
         out0_ready = ($urandom_range(0, 2) != 0);
         out1_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
